// File: rtl/uart_tx_if.sv
// Byte handshake bundle between a producer (master) and the UART transmitter (slave).
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART serializer, one byte per ready/valid handshake, LSB first, registered tx_pin.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_transmitter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx_if,
  output logic      tx_pin
);

  localparam int CYCLES_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  if (CYCLES_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_transmitter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             pin_q, pin_d;
  logic             bit_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pin_q   <= pin_d;
    end
  end

  assign bit_done = (cnt_q == CNT_LAST);

  // pin_d is decoded from the state being entered so tx_pin changes exactly on the transition edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    pin_d    = pin_q;
    cnt_d    = (state_q == IDLE || bit_done) ? '0 : cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        pin_d = 1'b1;
        if (tx_if.tx_data_valid) begin
          data_d  = tx_if.tx_data;
          state_d = START;
          pin_d   = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = 3'd0;
          state_d = DATA;
          pin_d   = data_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            pin_d   = ^data_q;
`else
            state_d = STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            pin_d = data_q[idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          pin_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          pin_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b1;
      end
    endcase
  end

  assign tx_if.tx_data_ready = (state_q == IDLE);
  assign tx_pin              = pin_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at C = 10 clocks per bit; frames decoded at mid-bit.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk;
  logic rst;
  logic tx_pin;
  int   checks;
  int   errors;
  logic last_par;

  uart_tx_if bus ();

  uart_transmitter #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tx_if  (bus.slave),
    .tx_pin (tx_pin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after acceptance edge E0; leaves just after edge E0+FB*10.
  task automatic run_frame(input logic [7:0] exp, input string tag, input bit disturb);
    logic [FB-1:0] rx;
    bit            rdy_bad;
    rx      = '0;
    rdy_bad = 1'b0;
    for (int t = 0; t < FB * 10; t++) begin
      if (bus.tx_data_ready !== 1'b0) rdy_bad = 1'b1;
      if (t % 10 == 5) rx[t / 10] = tx_pin;
      if (disturb) begin
        if (t == 29) begin
          bus.tx_data_valid = 1'b1;
          bus.tx_data       = 8'hFF;
        end
        if (t == 30) bus.tx_data_valid = 1'b0;
        if (t == 50) bus.tx_data = 8'h5A;
      end
      adv(1);
    end
    $display("frame %s: decoded %h expected %h", tag, rx[8:1], exp);
    chk({tag, " start"}, {7'd0, rx[0]}, 8'h00);
    chk({tag, " byte"}, rx[8:1], exp);
`ifdef UART_TX_PARITY_EN
    last_par = rx[9];
    chk({tag, " parity"}, {7'd0, rx[9]}, {7'd0, ^exp});
`endif
    chk({tag, " stop"}, {7'd0, rx[FB-1]}, 8'h01);
    chk({tag, " ready low in frame"}, {7'd0, rdy_bad}, 8'h00);
    chk({tag, " ready after frame"}, {7'd0, bus.tx_data_ready}, 8'h01);
    chk({tag, " pin after frame"}, {7'd0, tx_pin}, 8'h01);
  endtask

  task automatic send(input logic [7:0] b);
    bus.tx_data       = b;
    bus.tx_data_valid = 1'b1;
    adv(1);
    bus.tx_data_valid = 1'b0;
  endtask

  initial begin
    bit low_seen;
    checks            = 0;
    errors            = 0;
    last_par          = 1'b0;
    rst               = 1'b1;
    bus.tx_data       = 8'h00;
    bus.tx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset pin", {7'd0, tx_pin}, 8'h01);
    chk("reset ready", {7'd0, bus.tx_data_ready}, 8'h01);

    low_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      adv(1);
      if (tx_pin !== 1'b1) low_seen = 1'b1;
    end
    chk("idle line", {7'd0, low_seen}, 8'h00);

    // Single byte with immediate post-acceptance state.
    send(8'h55);
    chk("0x55 pin after E0", {7'd0, tx_pin}, 8'h00);
    chk("0x55 ready after E0", {7'd0, bus.tx_data_ready}, 8'h00);
    run_frame(8'h55, "0x55", 1'b0);

    // Back-to-back with valid held high.
    bus.tx_data       = 8'hA3;
    bus.tx_data_valid = 1'b1;
    adv(1);
    bus.tx_data = 8'h0F;
    run_frame(8'hA3, "b2b first", 1'b0);
    adv(1);
    bus.tx_data_valid = 1'b0;
    chk("b2b second start pin", {7'd0, tx_pin}, 8'h00);
    chk("b2b second start ready", {7'd0, bus.tx_data_ready}, 8'h00);
    run_frame(8'h0F, "b2b second", 1'b0);

    // Valid pulse and data change while busy must be ignored.
    send(8'h12);
    run_frame(8'h12, "busy ignore", 1'b1);
    low_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      adv(1);
      if (tx_pin !== 1'b1) low_seen = 1'b1;
    end
    chk("no extra frame", {7'd0, low_seen}, 8'h00);

    // Reset at edge E0+45 aborts the frame.
    send(8'h81);
    adv(44);
    rst = 1'b1;
    adv(1);
    chk("mid reset pin", {7'd0, tx_pin}, 8'h01);
    chk("mid reset ready", {7'd0, bus.tx_data_ready}, 8'h01);
    rst = 1'b0;
    adv(2);
    chk("post reset idle", {7'd0, tx_pin}, 8'h01);
    send(8'hC6);
    run_frame(8'hC6, "0xC6 after reset", 1'b0);

    // Reset together with valid: byte is not accepted.
    adv(3);
    rst               = 1'b1;
    bus.tx_data       = 8'h00;
    bus.tx_data_valid = 1'b1;
    adv(1);
    rst               = 1'b0;
    bus.tx_data_valid = 1'b0;
    adv(1);
    chk("rst+valid pin", {7'd0, tx_pin}, 8'h01);
    chk("rst+valid ready", {7'd0, bus.tx_data_ready}, 8'h01);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    run_frame(8'h07, "parity 0x07", 1'b0);
    chk("parity 0x07 bit", {7'd0, last_par}, 8'h01);
    adv(2);
    send(8'h03);
    run_frame(8'h03, "parity 0x03", 1'b0);
    chk("parity 0x03 bit", {7'd0, last_par}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
